// File: rtl/dsram_req_ctrl_if.sv
// Handshake bundle between MEM1, the data-SRAM port and MEM2.
// slave is the controller side, master the environment side.
interface dsram_req_ctrl_if;
  logic        m1s_req_valid;
  logic        m1s_req_wr;
  logic [1:0]  m1s_req_size;
  logic [31:0] m1s_req_addr;
  logic [3:0]  m1s_req_wstrb;
  logic [31:0] m1s_req_wdata;
  logic        m1s_req_ready;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        m2s_resp_valid;
  logic        m2s_resp_wr;
  logic [31:0] m2s_resp_rdata;
  logic        m2s_resp_ready;
  logic        flush;
  logic        busy;

  modport slave (
    input  m1s_req_valid, m1s_req_wr, m1s_req_size,
    input  m1s_req_addr, m1s_req_wstrb, m1s_req_wdata,
    output m1s_req_ready,
    output data_sram_req, data_sram_wr, data_sram_size,
    output data_sram_addr, data_sram_wstrb, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok,
    input  data_sram_rdata,
    output m2s_resp_valid, m2s_resp_wr, m2s_resp_rdata,
    input  m2s_resp_ready,
    input  flush,
    output busy
  );

  modport master (
    output m1s_req_valid, m1s_req_wr, m1s_req_size,
    output m1s_req_addr, m1s_req_wstrb, m1s_req_wdata,
    input  m1s_req_ready,
    input  data_sram_req, data_sram_wr, data_sram_size,
    input  data_sram_addr, data_sram_wstrb, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok,
    output data_sram_rdata,
    input  m2s_resp_valid, m2s_resp_wr, m2s_resp_rdata,
    output m2s_resp_ready,
    output flush,
    input  busy
  );
endinterface

// File: rtl/dsram_req_ctrl.sv
// Data-SRAM request controller: serialises MEM1 requests,
// returns in-order responses to MEM2, discards flushed ones.
module dsram_req_ctrl #(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 2
) (
  input logic             clk,
  input logic             reset,
  dsram_req_ctrl_if.slave bus
);

  localparam int TQ = 2**CNT_W;

  typedef enum logic {IDLE, ADDR} state_t;

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_out_cnt, r_disc_cnt, r_buf_cnt;
  logic [CNT_W-1:0] w_tpos;
  logic [CNT_W:0]   w_used;
  logic             w_credit, w_ready, w_accept;
  logic             w_tag_pop, w_live, w_bhas;
  logic             w_valid, w_pop_buf, w_push_buf;
  logic             w_resp_wr, w_bidx;
  logic             r_tag   [TQ];
  logic             w_tag_n [TQ];
  logic             r_bwr   [2];
  logic [31:0]      r_bdat  [2];
  logic             r_wr;
  logic [1:0]       r_size;
  logic [31:0]      r_addr, r_wdata;
  logic [3:0]       r_wstrb;

  assign w_used   = {1'b0, r_out_cnt} + {1'b0, r_buf_cnt};
  assign w_credit = w_used < (CNT_W+1)'(MAX_OUT);

  always_comb begin
    w_state_n = r_state;
    w_ready   = 1'b0;
    unique case (r_state)
      IDLE: w_ready = !bus.flush && w_credit;
      ADDR: w_ready = !bus.flush && w_credit
                      && bus.data_sram_addr_ok;
    endcase
    w_accept = w_ready && bus.m1s_req_valid;
    if (w_accept)
      w_state_n = ADDR;
    else if (r_state == ADDR && bus.data_sram_addr_ok)
      w_state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wstrb <= 4'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_wr    <= bus.m1s_req_wr;
      r_size  <= bus.m1s_req_size;
      r_addr  <= bus.m1s_req_addr;
      r_wstrb <= bus.m1s_req_wstrb;
      r_wdata <= bus.m1s_req_wdata;
    end
  end

  assign bus.m1s_req_ready   = w_ready;
  assign bus.data_sram_req   = (r_state == ADDR);
  assign bus.data_sram_wr    = r_wr;
  assign bus.data_sram_size  = r_size;
  assign bus.data_sram_addr  = r_addr;
  assign bus.data_sram_wstrb = r_wstrb;
  assign bus.data_sram_wdata = r_wdata;

  // Tag queue head is always entry 0; occupancy equals out_cnt.
  assign w_tag_pop = bus.data_sram_data_ok && r_out_cnt != '0;
  assign w_tpos    = r_out_cnt - CNT_W'(w_tag_pop);

  always_comb begin
    w_tag_n = r_tag;
    if (w_tag_pop)
      for (int i = 0; i < TQ-1; i++) w_tag_n[i] = r_tag[i+1];
    if (w_accept) w_tag_n[w_tpos] = bus.m1s_req_wr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TQ; i++) r_tag[i] <= 1'b0;
      r_out_cnt  <= '0;
      r_disc_cnt <= '0;
    end else begin
      r_tag     <= w_tag_n;
      r_out_cnt <= r_out_cnt + CNT_W'(w_accept)
                   - CNT_W'(w_tag_pop);
      if (bus.flush)
        r_disc_cnt <= r_out_cnt - CNT_W'(w_tag_pop);
      else if (bus.data_sram_data_ok && r_disc_cnt != '0)
        r_disc_cnt <= r_disc_cnt - 1'b1;
    end
  end

  assign w_live = bus.data_sram_data_ok && !bus.flush
                  && r_disc_cnt == '0;
  assign w_bhas    = r_buf_cnt != '0;
  assign w_valid   = !bus.flush && (w_bhas || w_live);
  assign w_resp_wr = w_bhas ? r_bwr[0] : r_tag[0];

  assign w_pop_buf  = w_valid && bus.m2s_resp_ready && w_bhas;
  assign w_push_buf = w_live && (w_bhas || !bus.m2s_resp_ready);
  assign w_bidx     = r_buf_cnt[0] ^ w_pop_buf;

  assign bus.m2s_resp_valid = w_valid;
  assign bus.m2s_resp_wr    = w_resp_wr;
  assign bus.m2s_resp_rdata = w_resp_wr ? 32'd0 :
    (w_bhas ? r_bdat[0] : bus.data_sram_rdata);

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_buf_cnt <= '0;
    end else begin
      r_buf_cnt <= r_buf_cnt - CNT_W'(w_pop_buf)
                   + CNT_W'(w_push_buf);
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop_buf) begin
      r_bwr[0]  <= r_bwr[1];
      r_bdat[0] <= r_bdat[1];
    end
    if (w_push_buf) begin
      r_bwr[w_bidx]  <= r_tag[0];
      r_bdat[w_bidx] <= bus.data_sram_rdata;
    end
  end

  assign bus.busy = r_out_cnt != '0 || r_buf_cnt != '0;

  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(w_live && r_buf_cnt == CNT_W'(2)))
        else $error("response buffer overflow");
  end

endmodule

// File: tb/tb_dsram_req_ctrl.sv
// Bench for dsram_req_ctrl: directed scenarios plus a
// randomized run against a transaction-level model.
module tb_dsram_req_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  dsram_req_ctrl_if bus ();

  dsram_req_ctrl #(.MAX_OUT(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { logic wr; logic canc; } txn_t;
  typedef struct { logic wr; logic [31:0] d; } rsp_t;

  task automatic idle_in();
    bus.m1s_req_valid = 1'b0;
    bus.m1s_req_wr = 1'b0;
    bus.m1s_req_size = 2'd0;
    bus.m1s_req_addr = 32'd0;
    bus.m1s_req_wstrb = 4'd0;
    bus.m1s_req_wdata = 32'd0;
    bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata = 32'd0;
    bus.m2s_resp_ready = 1'b1;
    bus.flush = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  task automatic req(input logic wr, input logic [31:0] a,
                     input logic [31:0] d);
    bus.m1s_req_valid = 1'b1;
    bus.m1s_req_wr = wr;
    bus.m1s_req_size = 2'd2;
    bus.m1s_req_addr = a;
    bus.m1s_req_wstrb = wr ? 4'hF : 4'h0;
    bus.m1s_req_wdata = d;
  endtask

  task automatic test_reset();
    logic [70:0] f;
    idle_in();
    reset = 1'b1;
    nxt();
    mid();
    f = {bus.data_sram_wr, bus.data_sram_size, bus.data_sram_addr,
         bus.data_sram_wstrb, bus.data_sram_wdata};
    n_chk++; if (bus.data_sram_req !== 1'b0) $display("FAIL rst_req got %b exp 0", bus.data_sram_req); else n_pass++;
    n_chk++; if (f !== 71'd0) $display("FAIL rst_fields got %h exp 0", f); else n_pass++;
    n_chk++; if (bus.m2s_resp_valid !== 1'b0) $display("FAIL rst_rvalid got %b exp 0", bus.m2s_resp_valid); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if (bus.m1s_req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", bus.m1s_req_ready); else n_pass++;
    nxt();
    reset = 1'b0;
  endtask

  task automatic test_single_load();
    do_reset();
    req(1'b0, 32'h100, 32'h0);
    mid();
    n_chk++; if (bus.m1s_req_ready !== 1'b1) $display("FAIL sl_ready got %b exp 1", bus.m1s_req_ready); else n_pass++;
    nxt();
    bus.m1s_req_valid = 1'b0;
    bus.data_sram_addr_ok = 1'b1;
    mid();
    n_chk++; if (bus.data_sram_req !== 1'b1) $display("FAIL sl_req got %b exp 1", bus.data_sram_req); else n_pass++;
    n_chk++; if (bus.data_sram_addr !== 32'h100) $display("FAIL sl_addr got %h exp 100", bus.data_sram_addr); else n_pass++;
    nxt();
    bus.data_sram_addr_ok = 1'b0;
    mid();
    n_chk++; if (bus.data_sram_req !== 1'b0) $display("FAIL sl_req_lo got %b exp 0", bus.data_sram_req); else n_pass++;
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL sl_busy got %b exp 1", bus.busy); else n_pass++;
    nxt();
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata = 32'hDEADBEEF;
    mid();
    n_chk++; if (bus.m2s_resp_valid !== 1'b1) $display("FAIL sl_rvalid got %b exp 1", bus.m2s_resp_valid); else n_pass++;
    n_chk++; if (bus.m2s_resp_wr !== 1'b0) $display("FAIL sl_rwr got %b exp 0", bus.m2s_resp_wr); else n_pass++;
    n_chk++; if (bus.m2s_resp_rdata !== 32'hDEADBEEF) $display("FAIL sl_rdata got %h exp deadbeef", bus.m2s_resp_rdata); else n_pass++;
    nxt();
    bus.data_sram_data_ok = 1'b0;
    mid();
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL sl_busy_end got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if (bus.m2s_resp_valid !== 1'b0) $display("FAIL sl_rvalid_end got %b exp 0", bus.m2s_resp_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req(1'b0, 32'hA10, 32'h0);
    nxt();
    req(1'b0, 32'hA20, 32'h0);
    bus.data_sram_addr_ok = 1'b1;
    mid();
    n_chk++; if (bus.m1s_req_ready !== 1'b1) $display("FAIL b2b_ready2 got %b exp 1", bus.m1s_req_ready); else n_pass++;
    nxt();
    req(1'b0, 32'hA30, 32'h0);
    mid();
    n_chk++; if (bus.data_sram_addr !== 32'hA20) $display("FAIL b2b_addr2 got %h exp a20", bus.data_sram_addr); else n_pass++;
    n_chk++; if (bus.m1s_req_ready !== 1'b0) $display("FAIL b2b_ready3 got %b exp 0", bus.m1s_req_ready); else n_pass++;
    nxt();
    bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata = 32'hA1;
    mid();
    n_chk++; if (bus.data_sram_req !== 1'b0) $display("FAIL b2b_req_lo got %b exp 0", bus.data_sram_req); else n_pass++;
    n_chk++; if (bus.m1s_req_ready !== 1'b0) $display("FAIL b2b_ready3b got %b exp 0", bus.m1s_req_ready); else n_pass++;
    n_chk++; if (bus.m2s_resp_rdata !== 32'hA1) $display("FAIL b2b_r1 got %h exp a1", bus.m2s_resp_rdata); else n_pass++;
    nxt();
    bus.data_sram_data_ok = 1'b0;
    mid();
    n_chk++; if (bus.m1s_req_ready !== 1'b1) $display("FAIL b2b_ready3c got %b exp 1", bus.m1s_req_ready); else n_pass++;
    nxt();
    bus.m1s_req_valid = 1'b0;
    bus.data_sram_addr_ok = 1'b1;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata = 32'hA2;
    mid();
    n_chk++; if (bus.data_sram_addr !== 32'hA30) $display("FAIL b2b_addr3 got %h exp a30", bus.data_sram_addr); else n_pass++;
    n_chk++; if (bus.m2s_resp_rdata !== 32'hA2) $display("FAIL b2b_r2 got %h exp a2", bus.m2s_resp_rdata); else n_pass++;
    nxt();
    bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_rdata = 32'hA3;
    mid();
    n_chk++; if (bus.m2s_resp_rdata !== 32'hA3) $display("FAIL b2b_r3 got %h exp a3", bus.m2s_resp_rdata); else n_pass++;
    nxt();
    bus.data_sram_data_ok = 1'b0;
    mid();
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL b2b_busy got %b exp 0", bus.busy); else n_pass++;
  endtask

  task automatic test_delayed_aok();
    do_reset();
    req(1'b1, 32'h200, 32'hCAFEF00D);
    nxt();
    req(1'b0, 32'h300, 32'h1);
    for (int i = 0; i < 5; i++) begin
      mid();
      n_chk++; if (bus.data_sram_req !== 1'b1) $display("FAIL da_req[%0d] got %b exp 1", i, bus.data_sram_req); else n_pass++;
      n_chk++; if (bus.data_sram_addr !== 32'h200) $display("FAIL da_addr[%0d] got %h exp 200", i, bus.data_sram_addr); else n_pass++;
      n_chk++; if (bus.data_sram_wdata !== 32'hCAFEF00D) $display("FAIL da_wdata[%0d] got %h exp cafef00d", i, bus.data_sram_wdata); else n_pass++;
      n_chk++; if (bus.data_sram_wstrb !== 4'hF) $display("FAIL da_wstrb[%0d] got %h exp f", i, bus.data_sram_wstrb); else n_pass++;
      n_chk++; if (bus.m1s_req_ready !== 1'b0) $display("FAIL da_ready[%0d] got %b exp 0", i, bus.m1s_req_ready); else n_pass++;
      nxt();
    end
    bus.m1s_req_valid = 1'b0;
    bus.data_sram_addr_ok = 1'b1;
    nxt();
    bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata = 32'h12345678;
    mid();
    n_chk++; if (bus.m2s_resp_valid !== 1'b1) $display("FAIL da_rvalid got %b exp 1", bus.m2s_resp_valid); else n_pass++;
    n_chk++; if (bus.m2s_resp_wr !== 1'b1) $display("FAIL da_rwr got %b exp 1", bus.m2s_resp_wr); else n_pass++;
    n_chk++; if (bus.m2s_resp_rdata !== 32'h0) $display("FAIL da_rdata got %h exp 0", bus.m2s_resp_rdata); else n_pass++;
    nxt();
    bus.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.m2s_resp_ready = 1'b0;
    req(1'b0, 32'h400, 32'h0);
    nxt();
    req(1'b0, 32'h404, 32'h0);
    bus.data_sram_addr_ok = 1'b1;
    nxt();
    bus.m1s_req_valid = 1'b0;
    nxt();
    bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata = 32'h11;
    mid();
    n_chk++; if (bus.m2s_resp_rdata !== 32'h11) $display("FAIL bp_byp got %h exp 11", bus.m2s_resp_rdata); else n_pass++;
    nxt();
    bus.data_sram_rdata = 32'h22;
    mid();
    n_chk++; if (bus.m2s_resp_rdata !== 32'h11) $display("FAIL bp_head got %h exp 11", bus.m2s_resp_rdata); else n_pass++;
    nxt();
    bus.data_sram_data_ok = 1'b0;
    req(1'b0, 32'h408, 32'h0);
    mid();
    n_chk++; if (dut.r_buf_cnt !== 2'd2) $display("FAIL bp_bufcnt got %0d exp 2", dut.r_buf_cnt); else n_pass++;
    n_chk++; if (bus.m1s_req_ready !== 1'b0) $display("FAIL bp_ready got %b exp 0", bus.m1s_req_ready); else n_pass++;
    nxt();
    bus.m1s_req_valid = 1'b0;
    bus.m2s_resp_ready = 1'b1;
    mid();
    n_chk++; if ({bus.m2s_resp_valid, bus.m2s_resp_rdata} !== {1'b1, 32'h11}) $display("FAIL bp_pop1 got %b/%h exp 1/11", bus.m2s_resp_valid, bus.m2s_resp_rdata); else n_pass++;
    nxt();
    mid();
    n_chk++; if ({bus.m2s_resp_valid, bus.m2s_resp_rdata} !== {1'b1, 32'h22}) $display("FAIL bp_pop2 got %b/%h exp 1/22", bus.m2s_resp_valid, bus.m2s_resp_rdata); else n_pass++;
    nxt();
    mid();
    n_chk++; if (bus.m2s_resp_valid !== 1'b0) $display("FAIL bp_empty got %b exp 0", bus.m2s_resp_valid); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL bp_busy got %b exp 0", bus.busy); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    req(1'b0, 32'h500, 32'h0);
    nxt();
    req(1'b0, 32'h504, 32'h0);
    bus.data_sram_addr_ok = 1'b1;
    nxt();
    req(1'b0, 32'h508, 32'h0);
    bus.data_sram_addr_ok = 1'b0;
    bus.flush = 1'b1;
    mid();
    n_chk++; if (bus.m1s_req_ready !== 1'b0) $display("FAIL fl_ready got %b exp 0", bus.m1s_req_ready); else n_pass++;
    n_chk++; if (bus.data_sram_req !== 1'b1) $display("FAIL fl_req got %b exp 1", bus.data_sram_req); else n_pass++;
    nxt();
    bus.flush = 1'b0;
    bus.m1s_req_valid = 1'b0;
    mid();
    n_chk++; if ({bus.data_sram_req, bus.data_sram_addr} !== {1'b1, 32'h504}) $display("FAIL fl_hold got %b/%h exp 1/504", bus.data_sram_req, bus.data_sram_addr); else n_pass++;
    nxt();
    bus.data_sram_addr_ok = 1'b1;
    nxt();
    bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata = 32'hBAD1;
    mid();
    n_chk++; if (bus.m2s_resp_valid !== 1'b0) $display("FAIL fl_drop1 got %b exp 0", bus.m2s_resp_valid); else n_pass++;
    nxt();
    bus.data_sram_rdata = 32'hBAD2;
    mid();
    n_chk++; if (bus.m2s_resp_valid !== 1'b0) $display("FAIL fl_drop2 got %b exp 0", bus.m2s_resp_valid); else n_pass++;
    nxt();
    bus.data_sram_data_ok = 1'b0;
    req(1'b0, 32'h600, 32'h0);
    mid();
    n_chk++; if (bus.m1s_req_ready !== 1'b1) $display("FAIL fl_new_ready got %b exp 1", bus.m1s_req_ready); else n_pass++;
    nxt();
    bus.m1s_req_valid = 1'b0;
    bus.data_sram_addr_ok = 1'b1;
    nxt();
    bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata = 32'h600D;
    mid();
    n_chk++; if ({bus.m2s_resp_valid, bus.m2s_resp_rdata} !== {1'b1, 32'h600D}) $display("FAIL fl_new_resp got %b/%h exp 1/600d", bus.m2s_resp_valid, bus.m2s_resp_rdata); else n_pass++;
    nxt();
    bus.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_flush_dok_reset();
    logic [70:0] f;
    do_reset();
    req(1'b0, 32'h700, 32'h0);
    nxt();
    req(1'b0, 32'h704, 32'h0);
    bus.data_sram_addr_ok = 1'b1;
    nxt();
    bus.m1s_req_valid = 1'b0;
    bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata = 32'hBAD3;
    bus.flush = 1'b1;
    mid();
    n_chk++; if (bus.m2s_resp_valid !== 1'b0) $display("FAIL fd_drop got %b exp 0", bus.m2s_resp_valid); else n_pass++;
    nxt();
    bus.flush = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    mid();
    n_chk++; if (dut.r_disc_cnt !== 2'd1) $display("FAIL fd_disc got %0d exp 1", dut.r_disc_cnt); else n_pass++;
    n_chk++; if (bus.data_sram_req !== 1'b1) $display("FAIL fd_req got %b exp 1", bus.data_sram_req); else n_pass++;
    nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    mid();
    f = {bus.data_sram_wr, bus.data_sram_size, bus.data_sram_addr,
         bus.data_sram_wstrb, bus.data_sram_wdata};
    n_chk++; if (bus.data_sram_req !== 1'b0) $display("FAIL fd_rst_req got %b exp 0", bus.data_sram_req); else n_pass++;
    n_chk++; if (f !== 71'd0) $display("FAIL fd_rst_fields got %h exp 0", f); else n_pass++;
    n_chk++; if ({bus.m2s_resp_valid, bus.busy} !== 2'b00) $display("FAIL fd_rst_vb got %b exp 00", {bus.m2s_resp_valid, bus.busy}); else n_pass++;
    n_chk++; if (bus.m1s_req_ready !== 1'b1) $display("FAIL fd_rst_ready got %b exp 1", bus.m1s_req_ready); else n_pass++;
    n_chk++; if (dut.r_disc_cnt !== 2'd0) $display("FAIL fd_rst_disc got %0d exp 0", dut.r_disc_cnt); else n_pass++;
  endtask

  task automatic test_random();
    txn_t        q_out[$];
    rsp_t        q_buf[$];
    logic        pend;
    logic [70:0] pend_f;
    int          n_sram;
    logic        e_rdy, live, e_valid, e_wr, take;
    logic [31:0] e_rd;
    do_reset();
    pend = 1'b0;
    pend_f = '0;
    n_sram = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.m1s_req_valid = 1'($urandom % 2);
      bus.m1s_req_wr = 1'($urandom % 2);
      bus.m1s_req_size = 2'($urandom % 3);
      bus.m1s_req_addr = $urandom;
      bus.m1s_req_wstrb = 4'($urandom);
      bus.m1s_req_wdata = $urandom;
      bus.data_sram_addr_ok = ($urandom % 10) < 6;
      bus.data_sram_data_ok = n_sram > 0 && ($urandom % 10) < 5;
      bus.data_sram_rdata = $urandom;
      bus.m2s_resp_ready = ($urandom % 10) < 6;
      bus.flush = ($urandom % 40) == 0;
      e_rdy = !bus.flush && (q_out.size() + q_buf.size() < 2)
              && (!pend || bus.data_sram_addr_ok);
      live = bus.data_sram_data_ok && !bus.flush
             && q_out.size() > 0 && !q_out[0].canc;
      e_valid = !bus.flush && (q_buf.size() > 0 || live);
      e_wr = 1'b0;
      e_rd = 32'd0;
      if (q_buf.size() > 0) begin
        e_wr = q_buf[0].wr;
        e_rd = q_buf[0].wr ? 32'd0 : q_buf[0].d;
      end else if (live) begin
        e_wr = q_out[0].wr;
        e_rd = q_out[0].wr ? 32'd0 : bus.data_sram_rdata;
      end
      mid();
      n_chk++; if (bus.m1s_req_ready !== e_rdy) $display("FAIL rnd_ready c%0d got %b exp %b", c, bus.m1s_req_ready, e_rdy); else n_pass++;
      n_chk++; if (bus.data_sram_req !== pend) $display("FAIL rnd_req c%0d got %b exp %b", c, bus.data_sram_req, pend); else n_pass++;
      if (pend) begin
        n_chk++; if ({bus.data_sram_wr, bus.data_sram_size, bus.data_sram_addr, bus.data_sram_wstrb, bus.data_sram_wdata} !== pend_f) $display("FAIL rnd_fields c%0d exp %h", c, pend_f); else n_pass++;
      end
      n_chk++; if (bus.m2s_resp_valid !== e_valid) $display("FAIL rnd_rvalid c%0d got %b exp %b", c, bus.m2s_resp_valid, e_valid); else n_pass++;
      if (e_valid) begin
        n_chk++; if ({bus.m2s_resp_wr, bus.m2s_resp_rdata} !== {e_wr, e_rd}) $display("FAIL rnd_resp c%0d got %b/%h exp %b/%h", c, bus.m2s_resp_wr, bus.m2s_resp_rdata, e_wr, e_rd); else n_pass++;
      end
      n_chk++; if (bus.busy !== (q_out.size() != 0 || q_buf.size() != 0)) $display("FAIL rnd_busy c%0d got %b", c, bus.busy); else n_pass++;
      take = e_valid && bus.m2s_resp_ready;
      if (live && (q_buf.size() > 0 || !take))
        q_buf.push_back('{wr: q_out[0].wr, d: bus.data_sram_rdata});
      if (take && q_buf.size() > 0 && !(q_buf.size() == 1 && live && !take))
        void'(q_buf.pop_front());
      if (bus.data_sram_data_ok) begin
        void'(q_out.pop_front());
        n_sram--;
      end
      if (bus.flush) begin
        foreach (q_out[i]) q_out[i].canc = 1'b1;
        q_buf.delete();
      end
      if (pend && bus.data_sram_addr_ok) begin
        n_sram++;
        pend = 1'b0;
      end
      if (e_rdy && bus.m1s_req_valid) begin
        q_out.push_back('{wr: bus.m1s_req_wr, canc: 1'b0});
        pend = 1'b1;
        pend_f = {bus.m1s_req_wr, bus.m1s_req_size, bus.m1s_req_addr,
                  bus.m1s_req_wstrb, bus.m1s_req_wdata};
      end
      nxt();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    test_reset();
    test_single_load();
    test_back_to_back();
    test_delayed_aok();
    test_backpressure();
    test_flush();
    test_flush_dok_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dsram_req_ctrl.md
# dsram_req_ctrl

Data-SRAM request controller between the MEM1 issue point and the SRAM-like data port. It serialises MEM1 load and store requests onto the `req`/`addr_ok`/`data_ok` handshake and caps the number of outstanding transactions. It returns responses to MEM2 in order, with a 2-entry response buffer for MEM2 back-pressure. On a writeback flush it discards the responses of every cancelled transaction without ever withdrawing a request the SRAM has not yet accepted.

## Interface
- MAX_OUT, 2, maximum outstanding transactions plus buffered responses (1..3)
- CNT_W, 2, width of the outstanding, discard and buffer counters
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- m1s_req_valid  in  1  MEM1 has a memory access
- m1s_req_wr  in  1  1 = store
- m1s_req_size  in  2  0 = byte, 1 = half, 2 = word
- m1s_req_addr  in  32  physical address
- m1s_req_wstrb  in  4  byte enables for stores
- m1s_req_wdata  in  32  store data
- m1s_req_ready  out  1  request accepted when valid && ready
- data_sram_req  out  1  request to SRAM port
- data_sram_wr / data_sram_size / data_sram_addr / data_sram_wstrb / data_sram_wdata  out  1/2/32/4/32  registered request fields
- data_sram_addr_ok  in  1  address phase accepted
- data_sram_data_ok  in  1  data phase done (loads and stores)
- data_sram_rdata  in  32  load data, valid with data_ok
- m2s_resp_valid  out  1  response available to MEM2
- m2s_resp_wr  out  1  response belongs to a store
- m2s_resp_rdata  out  32  load data (0 for stores)
- m2s_resp_ready  in  1  MEM2 consumes the response
- flush  in  1  writeback flush; cancels all accepted transactions
- busy  out  1  outstanding != 0 || buffered != 0

## Operation
- State machine:
  - IDLE: data_sram_req = 0.
  - ADDR: data_sram_req = 1 and the request fields are held stable.
- Accept rule: `m1s_req_ready = !flush && (out_cnt + buf_cnt < MAX_OUT) && (IDLE || (ADDR && addr_ok))`.
  - On accept, the request fields register and the state becomes or stays ADDR.
  - This gives back-to-back issue on the cycle addr_ok completes.
- ADDR with addr_ok and no new accept → IDLE.
- ADDR holds while addr_ok = 0, including during flush. A request is never withdrawn.
- out_cnt counts accepted transactions without data_ok.
  - +1 on accept, −1 on data_ok; both events in one cycle leave it unchanged.
- A per-transaction wr flag travels in a MAX_OUT-deep in-order tag queue so that responses carry m2s_resp_wr.
- Flush:
  - disc_cnt ← out_cnt minus (1 if data_ok that cycle).
  - buf_cnt ← 0.
  - m2s_resp_valid is forced 0 that cycle.
- Discard: data_ok while disc_cnt != 0 → disc_cnt −1 and the response is dropped. It never reaches MEM2 or the buffer.
- Response path (disc_cnt = 0, no flush):
  - Buffer head is presented first.
  - With the buffer empty, data_ok bypasses combinationally to m2s_resp_*.
  - If the presented response is not taken (ready = 0), data_ok is written into the buffer.
  - Pop on valid && ready.
- Credit rule guarantees the buffer never overflows. data_ok arriving with buf_cnt = 2 is impossible by construction; assert it in simulation.
- m2s_resp_rdata = 0 when m2s_resp_wr = 1.

## Timing
- Reset values:
  - state IDLE, data_sram_req 0, all request fields 0.
  - out_cnt, disc_cnt, buf_cnt 0.
  - m2s_resp_valid 0, busy 0.
  - m1s_req_ready 1 (if flush = 0).
- Reset mid-operation clears everything. SRAM responses arriving afterwards belong to the environment; the bench resets the SRAM model together with this block.
- Issue latency: accept in cycle T → data_sram_req = 1 in T+1.
- Response latency: data_ok in cycle T with buffer empty → m2s_resp_valid in T (combinational bypass).
- Buffered response: visible from the cycle after capture until popped.
- Simultaneous events:
  - Accept + addr_ok in the same cycle: old request completes and the new one is driven in T+1.
  - Flush + m1s_req_valid: not accepted.
  - Flush + data_ok: that response is dropped.

## Test plan
- Single load: accept addr 0x100 at T, addr_ok at T+1, data_ok with rdata 0xDEADBEEF at T+3 → m2s_resp_valid=1, wr=0, rdata 0xDEADBEEF at T+3; busy back to 0 at T+4.
- Back-to-back, MAX_OUT=2:
  - Two loads with addr_ok held 1 → second accepted on the first's addr_ok cycle.
  - Third request gets ready=0 until first data_ok.
  - Responses arrive in order.
- Delayed addr_ok: addr_ok low for 5 cycles → req and addr/wdata/wstrb stable all 5 cycles; ready=0 throughout.
- Back-pressure: m2s_resp_ready=0 while two data_ok arrive (0x11, 0x22) → buf_cnt=2, ready=0; on release, 0x11 then 0x22 are popped on consecutive cycles.
- Flush mid-flight:
  - Setup: one transaction in ADDR and one awaiting data_ok, then flush.
  - req stays high until addr_ok.
  - Both later data_ok are dropped (m2s_resp_valid stays 0).
  - A new load after the flush returns its own data correctly.
- Flush coincident with data_ok, plus reset asserted mid-ADDR → response dropped and disc_cnt = out_cnt−1; after reset all outputs equal their reset values.
